// File: rtl/cpu_pkg.sv
// Shared constants and helpers for the Harvard no-pipeline CPU blocks.
package cpu_pkg;

   localparam int CPU_ADDR_W      = 8;
   localparam int CPU_STACK_DEPTH = 4;

   // Stack pointer width: one extra bit so "full" (== depth) is representable.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int PTR_W = ptr_width(CPU_STACK_DEPTH);

endpackage : cpu_pkg

// File: rtl/lifo_stack.sv
// Bounded-depth LIFO for return addresses. Owns the storage, the full/empty
// guards and the sticky over/underflow flags. A simultaneous push and pop
// leaves the stack untouched; the caller flags that combination.
// DEPTH must be a power of two and at least 2.
module lifo_stack
   import cpu_pkg::*;
#(
   parameter int WIDTH = CPU_ADDR_W,
   parameter int DEPTH = CPU_STACK_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         top,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     full,
   output logic                     empty,
   output logic                     err_over,
   output logic                     err_under
);

   localparam int SP_W  = ptr_width(DEPTH);
   localparam int IDX_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [SP_W-1:0]  depth_m1;

   assign full     = (depth == SP_W'(DEPTH));
   assign empty    = (depth == '0);
   assign depth_m1 = depth - SP_W'(1);

   // Top of stack is the most recently written entry, or 0 when empty.
   always_comb begin
      top = '0;
      if (!empty) top = mem[depth_m1[IDX_W-1:0]];
   end

   // Storage, pointer and sticky error flags; guards keep the pointer in range.
   always_ff @(posedge clk) begin
      if (reset) begin
         depth     <= '0;
         err_over  <= 1'b0;
         err_under <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !pop) begin
         if (!full) begin
            mem[depth[IDX_W-1:0]] <= din;
            depth                 <= depth + SP_W'(1);
         end else begin
            err_over <= 1'b1;
         end
      end else if (pop && !push) begin
         if (!empty) depth     <= depth_m1;
         else        err_under <= 1'b1;
      end
   end

endmodule : lifo_stack

// File: rtl/pc_stack_unit.sv
// Program counter plus return-address stack. JMS = push + pc_load with
// stack_mux=0; BBL = pop + pc_load with stack_mux=1, which reads the pre-pop
// top of stack so a return completes in a single cycle.
module pc_stack_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W      = CPU_ADDR_W,
   parameter int STACK_DEPTH = CPU_STACK_DEPTH
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         pc_load,
   input  logic                         pc_inc,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         stack_mux,
   input  logic [ADDR_W-1:0]            jump_addr,
   output logic [ADDR_W-1:0]            pc,
   output logic [ADDR_W-1:0]            tos,
   output logic [$clog2(STACK_DEPTH):0] depth,
   output logic                         overflow,
   output logic                         underflow,
   output logic                         seq_err
);

   logic              stack_empty;
   logic              load_blocked;
   logic [ADDR_W-1:0] load_src;

   lifo_stack #(
      .WIDTH (ADDR_W),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .din       (pc),
      .top       (tos),
      .depth     (depth),
      .full      (),
      .empty     (stack_empty),
      .err_over  (overflow),
      .err_under (underflow)
   );

   // Load source select; a return from an empty stack must not jump anywhere.
   always_comb begin
      load_src     = stack_mux ? tos : jump_addr;
      load_blocked = stack_mux && pop && !push && stack_empty;
   end

   // PC register (load beats increment) and the sticky strobe-conflict flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= '0;
         seq_err <= 1'b0;
      end else begin
         if (pc_load) begin
            if (!load_blocked) pc <= load_src;
         end else if (pc_inc) begin
            pc <= pc + ADDR_W'(1);
         end
         if ((pc_load && pc_inc) || (push && pop)) seq_err <= 1'b1;
      end
   end

endmodule : pc_stack_unit

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Program-counter and return-address-stack stage for the Harvard no-pipeline CPU.
- Sits directly downstream of the instruction decoder. Consumes its pc_load, pc_inc, push, pop and stack_mux strobes plus the jump-target operand from instruction memory.
- Produces the instruction-memory fetch address.
- Implements JMS (jump to subroutine: push return address, jump) and BBL (branch back: pop return address into PC) with bounded-depth LIFO storage and sticky error flags.

Parameters:
- ADDR_W, 8, width of the PC, the jump target and each stack entry.
- STACK_DEPTH, 4, number of return-address entries. Must be a power of two and at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_load  input  1  load PC from the selected source this cycle.
- pc_inc  input  1  increment PC this cycle.
- push  input  1  push the current PC onto the return stack.
- pop  input  1  pop the return stack.
- stack_mux  input  1  PC load source: 0 = jump_addr, 1 = top of stack.
- jump_addr  input  ADDR_W  jump/call target operand from instruction memory.
- pc  output  ADDR_W  current program counter, used as the fetch address.
- tos  output  ADDR_W  current top-of-stack value; 0 when the stack is empty.
- depth  output  $clog2(STACK_DEPTH)+1  number of valid stack entries.
- overflow  output  1  sticky: a push was attempted while the stack was full.
- underflow  output  1  sticky: a pop was attempted while the stack was empty.
- seq_err  output  1  sticky: an illegal strobe combination was received.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - pc=0, depth=0, tos=0, overflow=0, underflow=0, seq_err=0.
  - All stack entries cleared to 0.
  - Reset overrides every other input in the same cycle, including mid-call.
- PC update priority, per edge:
  - pc_load=1: pc <= stack_mux ? tos : jump_addr.
  - Else pc_inc=1: pc <= pc+1, modulo 2^ADDR_W (wraps to 0 from all-ones, no flag).
  - Else pc holds.
- Simultaneous pc_load and pc_inc: the load wins, and seq_err is set.
- Push (push=1, pop=0):
  - If depth<STACK_DEPTH: write the pre-edge pc value into entry[depth], then depth+1.
  - If full: stack unchanged, overflow<=1.
  - Any concurrent pc_load still takes effect.
- Pop (pop=1, push=0):
  - If depth>0: depth-1.
  - The concurrent pc_load with stack_mux=1 uses the pre-pop tos, so the return address is consumed in one cycle.
  - If empty: underflow<=1, depth stays 0, and pc holds (the load is suppressed) when stack_mux=1.
- push=1 and pop=1 together: no stack change, seq_err<=1, and the PC update applies normally.
- stack_mux=1 with pc_load=0: no effect (stack_mux is only a source select).
- tos is combinational: entry[depth-1] when depth>0, else 0.
- Latency:
  - pc is registered; a new fetch address is visible the cycle after the strobe edge.
  - tos and depth reflect stack changes on the same edge.
- Sticky flags clear only on reset.
- Stack pointer arithmetic uses ADDR_W-independent counter width, $clog2(STACK_DEPTH)+1 bits. It never wraps: the full and empty guards above prevent it.

Decomposition:
- Shared package cpu_pkg holds:
  - default constants CPU_ADDR_W=8 and CPU_STACK_DEPTH=4;
  - a localparam PTR_W helper.
- One sub-module: lifo_stack (parameters WIDTH, DEPTH).
  - Ports: push, pop, din, top, depth, full, empty, err_over, err_under.
  - It owns the storage and the guards.
- pc_stack_unit owns the PC register, source mux, priority logic and seq_err.

Test Plan:
- Reset then 3 cycles of pc_inc=1 -> pc 0,1,2,3, depth=0, all flags 0.
- pc=0x10, then pc_load=1, push=1, jump_addr=0x40 (JMS) -> next cycle pc=0x40, depth=1, tos=0x10. Then pc_load=1, pop=1, stack_mux=1 (BBL) -> pc=0x10, depth=0, tos=0.
- Four nested JMS from pc=0x01,0x21,0x31,0x41 -> depth=4, tos=0x41. A fifth push -> overflow=1, depth=4, pc still loads the target. Four BBLs -> pc=0x41,0x31,0x21,0x01 in order.
- BBL with depth=0 -> underflow=1, pc unchanged, depth=0.
- pc=0xFF with pc_inc -> pc=0x00, no flag. pc_load+pc_inc with jump_addr=0x22 -> pc=0x22, seq_err=1.
- JMS in progress (push+pc_load) with reset=1 on the same edge -> pc=0, depth=0, flags 0.
